imem_loader: RTL and testbench



---
 rtl/imem_loader.sv | 145 ++++++++++++++
 tb/tb_imem_loader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot loader: receives a framed little-endian byte stream, writes 32-bit words into
// instruction memory, and releases the core from reset only after a clean checksum.
module imem_loader #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_rst_n,
   output logic              busy,
   output logic              done,
   output logic              err
);

   // Handshake: a byte transfers on a rising clk edge where byte_valid && byte_ready.
   // byte_ready depends only on the state, never on byte_valid.
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HDR0 = 3'd1,
      S_HDR1 = 3'd2,
      S_WORD = 3'd3,
      S_CHK  = 3'd4
   } state_t;

   localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

   state_t      state;
   state_t      state_nx;
   logic        accept;
   logic [7:0]  n_lo;
   logic [15:0] n_words;
   logic [15:0] n_hdr;
   logic [15:0] word_cnt;
   logic [1:0]  byte_idx;
   logic [23:0] shift;
   logic [7:0]  csum;
   logic        oversize;
   logic        last_word;

   assign byte_ready = (state != S_IDLE);
   assign busy       = (state != S_IDLE);
   assign accept     = byte_valid && byte_ready;
   assign n_hdr      = {byte_data, n_lo};
   assign oversize   = ({1'b0, n_hdr} > CAPACITY);
   assign last_word  = (word_cnt == n_words - 16'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: if (start) state_nx = S_HDR0;
         S_HDR0: if (accept) state_nx = S_HDR1;
         S_HDR1: begin
            if (accept) begin
               if (oversize)           state_nx = S_IDLE;
               else if (n_hdr == 16'd0) state_nx = S_CHK;
               else                    state_nx = S_WORD;
            end
         end
         S_WORD: if (accept && byte_idx == 2'd3 && last_word) state_nx = S_CHK;
         S_CHK:  if (accept) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         core_rst_n <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         n_lo       <= '0;
         n_words    <= '0;
         word_cnt   <= '0;
         byte_idx   <= '0;
         shift      <= '0;
         csum       <= '0;
      end else begin
         imem_we <= 1'b0;
         done    <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  err        <= 1'b0;
                  core_rst_n <= 1'b0;
                  csum       <= '0;
                  word_cnt   <= '0;
                  byte_idx   <= '0;
               end
            end
            S_HDR0: begin
               if (accept) begin
                  n_lo <= byte_data;
                  csum <= csum ^ byte_data;
               end
            end
            S_HDR1: begin
               if (accept) begin
                  n_words <= n_hdr;
                  csum    <= csum ^ byte_data;
                  if (oversize) err <= 1'b1;
               end
            end
            S_WORD: begin
               if (accept) begin
                  csum     <= csum ^ byte_data;
                  byte_idx <= byte_idx + 2'd1;
                  shift    <= {byte_data, shift[23:8]};
                  // Fourth byte completes the word; the write strobe lands next cycle.
                  if (byte_idx == 2'd3) begin
                     imem_we    <= 1'b1;
                     imem_addr  <= word_cnt[ADDR_W-1:0];
                     imem_wdata <= {byte_data, shift};
                     word_cnt   <= word_cnt + 16'd1;
                  end
               end
            end
            S_CHK: begin
               if (accept) begin
                  if (csum == byte_data) begin
                     done       <= 1'b1;
                     core_rst_n <= 1'b1;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames are streamed byte by byte, expected memory
// writes are queued as the completing byte is driven and matched against imem_we.
module tb_imem_loader;
   localparam int ADDR_W = 10;

   logic              clk;
   logic              rst;
   logic              start;
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              core_rst_n;
   logic              busy;
   logic              done;
   logic              err;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   logic [ADDR_W+31:0] exp_q[$];
   logic [7:0] frame[0:15];
   int flen;

   imem_loader #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
      .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .core_rst_n(core_rst_n), .busy(busy), .done(done), .err(err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Write monitor: every strobe must match the oldest queued expectation.
   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
      if (imem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            assert (exp_q.size() != 0) else begin
               bad++;
               $error("FAIL unexpected_write observed=%0h:%0h expected=none", imem_addr, imem_wdata);
            end
         end else begin
            chk("write", {imem_addr, imem_wdata}, exp_q.pop_front());
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      chk("byte_ready", byte_ready, 1);
      byte_valid = 1'b1;
      byte_data  = b;
      @(negedge clk);
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      repeat (gap) @(negedge clk);
   endtask

   // Streams frame[0..nsend-1]; payload bytes are frame[2..flen-2].
   task automatic send_frame(input int max_gap, input bit spur, input int nsend);
      logic [31:0] w;
      w = '0;
      for (int i = 0; i < nsend; i++) begin
         if (i >= 2 && i < flen - 1) begin
            w = {frame[i], w[31:8]};
            if ((i - 2) % 4 == 3) exp_q.push_back({ADDR_W'((i - 2) / 4), w});
         end
         if (spur && i == 5) start = 1'b1;
         send_byte(frame[i], (i == nsend - 1) ? 0 : int'($urandom_range(0, max_gap)));
         start = 1'b0;
      end
   endtask

   task automatic set_nominal(input logic [7:0] last);
      frame[0] = 8'h02; frame[1] = 8'h00;
      frame[2] = 8'h78; frame[3] = 8'h56; frame[4] = 8'h34; frame[5] = 8'h12;
      frame[6] = 8'hEF; frame[7] = 8'hBE; frame[8] = 8'hAD; frame[9] = 8'hDE;
      frame[10] = last;
      flen = 11;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_busy", busy, 1);
      chk("start_ready", byte_ready, 1);
      chk("start_core_rst_n", core_rst_n, 0);
      chk("start_err", err, 0);
   endtask

   task automatic check_done_ok(input string tag);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_core_rst_n"}, core_rst_n, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_err"}, err, 0);
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, done, 0);
      chk({tag, "_core_rst_n_held"}, core_rst_n, 1);
      chk({tag, "_done_cnt"}, done_cnt, 1);
      chk({tag, "_queue_empty"}, exp_q.size(), 0);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_byte_ready"}, byte_ready, 0);
      chk({tag, "_imem_we"}, imem_we, 0);
      chk({tag, "_imem_addr"}, imem_addr, 0);
      chk({tag, "_imem_wdata"}, imem_wdata, 0);
      chk({tag, "_core_rst_n"}, core_rst_n, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
      #3;
      check_reset_values("por");
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Nominal load at full rate.
      set_nominal(8'h28);
      done_cnt = 0;
      do_start();
      send_frame(0, 1'b0, flen);
      check_done_ok("nominal");

      // Bad checksum: writes still happen, core stays held.
      set_nominal(8'h29);
      done_cnt = 0;
      do_start();
      chk("reload_core_rst_n", core_rst_n, 0);
      send_frame(0, 1'b0, flen);
      chk("badsum_err", err, 1);
      chk("badsum_done", done, 0);
      chk("badsum_core_rst_n", core_rst_n, 0);
      chk("badsum_busy", busy, 0);
      @(negedge clk);
      chk("badsum_done_cnt", done_cnt, 0);
      chk("badsum_queue_empty", exp_q.size(), 0);
      chk("badsum_err_sticky", err, 1);

      // Zero-length frame; the start also clears the sticky error.
      frame[0] = 8'h00; frame[1] = 8'h00; frame[2] = 8'h00; flen = 3;
      done_cnt = 0;
      do_start();
      send_frame(0, 1'b0, flen);
      check_done_ok("zero");

      // Oversize count 0x0401 aborts after the header with no writes.
      do_start();
      send_byte(8'h01, 0);
      send_byte(8'h04, 0);
      chk("oversize_err", err, 1);
      chk("oversize_busy", busy, 0);
      chk("oversize_ready", byte_ready, 0);
      chk("oversize_core_rst_n", core_rst_n, 0);
      repeat (3) @(negedge clk);
      chk("oversize_err_sticky", err, 1);

      // Throttled stream with a spurious start mid-session.
      set_nominal(8'h28);
      done_cnt = 0;
      do_start();
      send_frame(3, 1'b1, flen);
      check_done_ok("throttled");

      // Reset after five payload bytes: word 0 is written, then everything resets.
      set_nominal(8'h28);
      do_start();
      send_frame(0, 1'b0, 7);
      #2;
      rst = 1'b1;
      #1;
      check_reset_values("midrst");
      chk("midrst_word0_written", exp_q.size(), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_idle_busy", busy, 0);

      set_nominal(8'h28);
      done_cnt = 0;
      do_start();
      send_frame(0, 1'b0, flen);
      check_done_ok("after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
